signal_sweep_ctrl: RTL and testbench

SIGNAL_SWEEP_CTRL -- requirements
Module: signal_sweep_ctrl

---
 rtl/signal_sweep_ctrl_pkg.sv | 27 ++
 rtl/signal_sweep_ctrl_sweep_coord_gen.sv | 63 ++++++
 rtl/signal_sweep_ctrl.sv | 171 +++++++++++++++++
 tb/tb_signal_sweep_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/signal_sweep_ctrl_pkg.sv
// Shared parameters for the signal sweep controller: signal/ant widths,
// sweep FSM encoding and the 3x3 neighbourhood offset table.
package signal_sweep_ctrl_pkg;

    localparam int SIGNAL_bits = 8;
    localparam int ANT_num     = 2;
    localparam int NUM_SLOTS   = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } sweep_state_e;

    typedef logic signed [1:0] nb_off_t;

    // Slot 0 is the centre; slots 1..8 are NW,N,NE,W,E,SW,S,SE.
    localparam nb_off_t NB_DX [NUM_SLOTS] = '{
        2'sd0, -2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd1, -2'sd1, 2'sd0, 2'sd1
    };
    localparam nb_off_t NB_DY [NUM_SLOTS] = '{
        2'sd0, -2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1
    };

endpackage

// File: rtl/signal_sweep_ctrl_sweep_coord_gen.sv
// Raster cell counter plus neighbour coordinate / off-grid generation for
// the slot currently being fetched.
module sweep_coord_gen
    import signal_sweep_ctrl_pkg::*;
#(
    parameter int GRID_W = 16,
    parameter int GRID_H = 16,
    parameter int XW     = $clog2(GRID_W),
    parameter int YW     = $clog2(GRID_H)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          advance_i,
    input  logic [3:0]    slot_i,
    output logic [XW-1:0] cell_x_o,
    output logic [YW-1:0] cell_y_o,
    output logic [XW-1:0] nb_x_o,
    output logic [YW-1:0] nb_y_o,
    output logic          off_grid_o,
    output logic          last_cell_o
);

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    nb_off_t       dx;
    nb_off_t       dy;
    int            nx;
    int            ny;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q <= '0;
            y_q <= '0;
        end else if (advance_i) begin
            if (x_q == XW'(GRID_W - 1)) begin
                x_q <= '0;
                y_q <= (y_q == YW'(GRID_H - 1)) ? '0 : y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

    // Signed integer compares so a neighbour at -1 or GRID is never aliased.
    always_comb begin
        dx = NB_DX[0];
        dy = NB_DY[0];
        if (slot_i < 4'd9) begin
            dx = NB_DX[slot_i];
            dy = NB_DY[slot_i];
        end
        nx = int'(x_q) + int'(dx);
        ny = int'(y_q) + int'(dy);
        off_grid_o = (nx < 0) || (nx >= GRID_W) || (ny < 0) || (ny >= GRID_H);
        nb_x_o = XW'(nx);
        nb_y_o = YW'(ny);
    end

    assign cell_x_o    = x_q;
    assign cell_y_o    = y_q;
    assign last_cell_o = (x_q == XW'(GRID_W - 1)) && (y_q == YW'(GRID_H - 1));

endmodule

// File: rtl/signal_sweep_ctrl.sv
// Double-buffered field sweep: per cell, fetch the 3x3 neighbourhood from
// cur_bank, hand it to the datapath, and write the new value to ~cur_bank.
module signal_sweep_ctrl
    import signal_sweep_ctrl_pkg::*;
#(
    parameter int GRID_W = 16,
    parameter int GRID_H = 16,
    parameter int ADDR_W = $clog2(GRID_W * GRID_H)
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          cur_bank,
    output logic                          mem_rd_en,
    output logic                          mem_rd_bank,
    output logic [ADDR_W-1:0]             mem_rd_addr,
    input  logic [SIGNAL_bits-1:0]        mem_rd_data,
    output logic                          mem_wr_en,
    output logic                          mem_wr_bank,
    output logic [ADDR_W-1:0]             mem_wr_addr,
    output logic [SIGNAL_bits-1:0]        mem_wr_data,
    output logic [SIGNAL_bits-1:0]        dp_center,
    output logic [7:0][SIGNAL_bits-1:0]   dp_surround,
    output logic [7:0]                    dp_border_mask,
    output logic [ANT_num-1:0]            dp_is_updating,
    input  logic [SIGNAL_bits-1:0]        dp_new_signal,
    output logic [$clog2(GRID_W)-1:0]     cell_x,
    output logic [$clog2(GRID_H)-1:0]     cell_y,
    input  logic [ANT_num-1:0]            ant_at_cell,
    input  logic                          host_wr_valid,
    output logic                          host_wr_ready,
    input  logic [ADDR_W-1:0]             host_addr,
    input  logic [SIGNAL_bits-1:0]        host_data,
    output logic [2:0]                    dbg_state
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);

    sweep_state_e               state_q, state_d;
    logic [3:0]                 slot_q, slot_d;
    logic                       cur_bank_q;
    logic [SIGNAL_bits-1:0]     center_q;
    logic [7:0][SIGNAL_bits-1:0] surround_q;
    logic [7:0]                 mask_q;
    logic                       cap_pend_q;
    logic [3:0]                 cap_slot_q;
    logic                       cap_off_q;

    logic [XW-1:0]              nb_x;
    logic [YW-1:0]              nb_y;
    logic                       off_grid;
    logic                       last_cell;
    logic                       fetch;
    logic                       in_write;
    logic                       host_accept;
    logic [2:0]                 issue_idx;
    logic [2:0]                 cap_idx;
    logic [ADDR_W-1:0]          cell_addr;

    sweep_coord_gen #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .XW     (XW),
        .YW     (YW)
    ) u_coord (
        .clk_i       (Clk),
        .rst_ni      (Reset_n),
        .advance_i   (in_write),
        .slot_i      (slot_q),
        .cell_x_o    (cell_x),
        .cell_y_o    (cell_y),
        .nb_x_o      (nb_x),
        .nb_y_o      (nb_y),
        .off_grid_o  (off_grid),
        .last_cell_o (last_cell)
    );

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        case (state_q)
            IDLE: begin
                slot_d = '0;
                if (start) state_d = FETCH;
            end
            FETCH: begin
                if (slot_q == 4'd8) begin
                    state_d = DRAIN;
                    slot_d  = '0;
                end else begin
                    slot_d = slot_q + 4'd1;
                end
            end
            DRAIN:   state_d = WRITE;
            WRITE:   state_d = last_cell ? DONE : FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    assign fetch       = (state_q == FETCH);
    assign in_write    = (state_q == WRITE);
    assign issue_idx   = 3'(slot_q - 4'd1);
    assign cap_idx     = 3'(cap_slot_q - 4'd1);
    assign cell_addr   = ADDR_W'(cell_y) * ADDR_W'(GRID_W) + ADDR_W'(cell_x);

    // Slot k is issued in FETCH cycle k and captured one cycle later; an
    // off-grid slot reuses the centre, which is always captured first.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cur_bank_q <= 1'b0;
            center_q   <= '0;
            surround_q <= '0;
            mask_q     <= '0;
            cap_pend_q <= 1'b0;
            cap_slot_q <= '0;
            cap_off_q  <= 1'b0;
        end else begin
            cap_pend_q <= fetch;
            cap_slot_q <= slot_q;
            cap_off_q  <= off_grid;
            if (fetch) begin
                if (slot_q == 4'd0) mask_q <= '0;
                else if (off_grid) mask_q[issue_idx] <= 1'b1;
            end
            if (cap_pend_q) begin
                if (cap_slot_q == 4'd0) center_q <= mem_rd_data;
                else surround_q[cap_idx] <= cap_off_q ? center_q : mem_rd_data;
            end
            if (state_q == DONE) cur_bank_q <= ~cur_bank_q;
        end
    end

    // Host writes share the write port; they are only taken while idle and
    // lose to a simultaneous start.
    assign host_wr_ready = (state_q == IDLE) && !start;
    assign host_accept   = host_wr_valid && host_wr_ready;

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign cur_bank       = cur_bank_q;
    assign dbg_state      = state_q;

    assign mem_rd_en      = fetch && !off_grid;
    assign mem_rd_bank    = cur_bank_q;
    assign mem_rd_addr    = ADDR_W'(nb_y) * ADDR_W'(GRID_W) + ADDR_W'(nb_x);

    assign mem_wr_en      = in_write || host_accept;
    assign mem_wr_bank    = in_write ? ~cur_bank_q : cur_bank_q;
    assign mem_wr_addr    = in_write ? cell_addr : host_addr;
    assign mem_wr_data    = in_write ? dp_new_signal : host_data;

    assign dp_center      = center_q;
    assign dp_surround    = surround_q;
    assign dp_border_mask = mask_q;
    assign dp_is_updating = in_write ? ant_at_cell : '0;

endmodule

// File: tb/tb_signal_sweep_ctrl.sv
// Directed bench for signal_sweep_ctrl on a 4x4 grid with a two-bank
// memory model, a +1 datapath and an ant parked at cell (2,2).
module tb_signal_sweep_ctrl;
    import signal_sweep_ctrl_pkg::*;

    localparam int GW = 4;
    localparam int GH = 4;
    localparam int AW = 4;
    localparam int SB = SIGNAL_bits;
    localparam int AN = ANT_num;
    localparam int LOGN = 256;

    logic                Clk;
    logic                Reset_n;
    logic                start;
    logic                busy, done, cur_bank;
    logic                mem_rd_en, mem_rd_bank;
    logic [AW-1:0]       mem_rd_addr;
    logic [SB-1:0]       mem_rd_data;
    logic                mem_wr_en, mem_wr_bank;
    logic [AW-1:0]       mem_wr_addr;
    logic [SB-1:0]       mem_wr_data;
    logic [SB-1:0]       dp_center;
    logic [7:0][SB-1:0]  dp_surround;
    logic [7:0]          dp_border_mask;
    logic [AN-1:0]       dp_is_updating;
    logic [SB-1:0]       dp_new_signal;
    logic [1:0]          cell_x, cell_y;
    logic [AN-1:0]       ant_at_cell;
    logic                host_wr_valid, host_wr_ready;
    logic [AW-1:0]       host_addr;
    logic [SB-1:0]       host_data;
    logic [2:0]          dbg_state;

    int total;
    int bad;

    signal_sweep_ctrl #(.GRID_W(GW), .GRID_H(GH), .ADDR_W(AW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .busy(busy), .done(done),
        .cur_bank(cur_bank), .mem_rd_en(mem_rd_en), .mem_rd_bank(mem_rd_bank),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en),
        .mem_wr_bank(mem_wr_bank), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .dp_center(dp_center), .dp_surround(dp_surround), .dp_border_mask(dp_border_mask),
        .dp_is_updating(dp_is_updating), .dp_new_signal(dp_new_signal),
        .cell_x(cell_x), .cell_y(cell_y), .ant_at_cell(ant_at_cell),
        .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
        .host_addr(host_addr), .host_data(host_data), .dbg_state(dbg_state)
    );

    // ---------------- clock / environment models ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [SB-1:0] mem [0:2*GW*GH-1];
    initial for (int i = 0; i < 2*GW*GH; i++) mem[i] = '0;

    always @(posedge Clk) begin
        if (mem_rd_en) mem_rd_data <= mem[{mem_rd_bank, mem_rd_addr}];
        if (mem_wr_en) mem[{mem_wr_bank, mem_wr_addr}] <= mem_wr_data;
    end

    assign dp_new_signal = dp_center + 8'd1;
    assign ant_at_cell   = (cell_x == 2'd2 && cell_y == 2'd2) ? 2'd1 : 2'd0;

    // ---------------- per-cycle sweep log ----------------
    logic               lg_done  [0:LOGN-1];
    logic               lg_rdy   [0:LOGN-1];
    logic               lg_wr_en [0:LOGN-1];
    logic               lg_wr_bk [0:LOGN-1];
    logic [AW-1:0]      lg_wr_ad [0:LOGN-1];
    logic [SB-1:0]      lg_wr_dt [0:LOGN-1];
    logic               lg_rd_en [0:LOGN-1];
    logic [AW-1:0]      lg_rd_ad [0:LOGN-1];
    logic [AN-1:0]      lg_upd   [0:LOGN-1];
    logic [7:0]         lg_mask  [0:LOGN-1];
    logic [SB-1:0]      lg_ctr   [0:LOGN-1];
    logic [7:0][SB-1:0] lg_sur   [0:LOGN-1];

    logic [AW+SB:0] exp_q[$];

    task automatic kick_start();
        @(negedge Clk);
        start = 1'b1;
        @(posedge Clk);
        #1 start = 1'b0;
    endtask

    // Records one sweep, cycle 1 being the first busy cycle; bounded.
    task automatic log_sweep(output int n_busy);
        for (int c = 0; c < LOGN; c++) begin
            lg_done[c] = 1'b0; lg_wr_en[c] = 1'b0; lg_rd_en[c] = 1'b0;
            lg_upd[c] = '0; lg_rdy[c] = 1'b0;
        end
        n_busy = 0;
        for (int c = 1; c < LOGN - 1; c++) begin
            @(negedge Clk);
            if (busy !== 1'b1) break;
            n_busy      = c;
            lg_done[c]  = done;
            lg_rdy[c]   = host_wr_ready;
            lg_wr_en[c] = mem_wr_en;
            lg_wr_bk[c] = mem_wr_bank;
            lg_wr_ad[c] = mem_wr_addr;
            lg_wr_dt[c] = mem_wr_data;
            lg_rd_en[c] = mem_rd_en;
            lg_rd_ad[c] = mem_rd_addr;
            lg_upd[c]   = dp_is_updating;
            lg_mask[c]  = dp_border_mask;
            lg_ctr[c]   = dp_center;
            lg_sur[c]   = dp_surround;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Reset_n = 1'b0; start = 1'b0; host_wr_valid = 1'b0; host_addr = '0; host_data = '0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (cur_bank !== 1'b0) begin bad++; $display("FAIL reset_bank got=%b exp=0", cur_bank); end
        total++; if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b exp=0", mem_rd_en); end
        total++; if (mem_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", mem_wr_en); end
        total++; if (host_wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", host_wr_ready); end
        total++; if (dp_border_mask !== 8'h00) begin bad++; $display("FAIL reset_mask got=%h exp=00", dp_border_mask); end
        total++; if ({cell_x, cell_y} !== 4'h0) begin bad++; $display("FAIL reset_cell got=%h exp=0", {cell_x, cell_y}); end
        total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    endtask

    // Loads the bank selected by cur_bank: flat=1 -> all 100, else a*7+3.
    task automatic test_host_write(input bit flat, input bit exp_bank);
        logic [SB-1:0] v;
        for (int a = 0; a < GW*GH; a++) begin
            v = flat ? 8'd100 : 8'(a*7 + 3);
            @(negedge Clk);
            host_wr_valid = 1'b1; host_addr = 4'(a); host_data = v;
            #1;
            total++;
            if ({host_wr_ready, mem_wr_en, mem_wr_bank, mem_wr_addr, mem_wr_data} !== {2'b11, exp_bank, 4'(a), v}) begin
                bad++;
                $display("FAIL host_wr a=%0d got rdy=%b en=%b bk=%b ad=%0d d=%0d exp bk=%b d=%0d",
                         a, host_wr_ready, mem_wr_en, mem_wr_bank, mem_wr_addr, mem_wr_data, exp_bank, v);
            end
        end
        @(negedge Clk);
        host_wr_valid = 1'b0;
    endtask

    task automatic test_sweep_pattern();
        int n, wr_cnt, done_cnt;
        logic [AW+SB:0] e;
        logic [AW-1:0] rd_got[$];
        logic [AW-1:0] exp_rd [4];
        logic [SB-1:0] exp_sur [8];
        exp_rd  = '{4'd0, 4'd1, 4'd4, 4'd5};
        exp_sur = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd10, 8'd3, 8'd31, 8'd38};
        exp_q.delete();
        for (int a = 0; a < GW*GH; a++) exp_q.push_back({1'b1, 4'(a), 8'(a*7 + 4)});
        kick_start();
        log_sweep(n);
        total++; if (n != 177) begin bad++; $display("FAIL sweep_busy_cycles got=%0d exp=177", n); end
        total++; if (cur_bank !== 1'b1) begin bad++; $display("FAIL sweep_bank_after got=%b exp=1", cur_bank); end
        done_cnt = 0;
        for (int c = 1; c <= n; c++) if (lg_done[c] === 1'b1) done_cnt++;
        total++; if (done_cnt != 1) begin bad++; $display("FAIL sweep_done_count got=%0d exp=1", done_cnt); end
        total++; if (lg_done[177] !== 1'b1) begin bad++; $display("FAIL sweep_done_cycle got=%b exp=1", lg_done[177]); end
        wr_cnt = 0;
        for (int c = 1; c <= n; c++) begin
            if (lg_wr_en[c] === 1'b1) begin
                wr_cnt++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                total++;
                if ({lg_wr_bk[c], lg_wr_ad[c], lg_wr_dt[c]} !== e) begin
                    bad++;
                    $display("FAIL sweep_write c=%0d got bk=%b ad=%0d d=%0d exp bk=%b ad=%0d d=%0d",
                             c, lg_wr_bk[c], lg_wr_ad[c], lg_wr_dt[c], e[12], e[11:8], e[7:0]);
                end
            end
        end
        total++; if (wr_cnt != 16) begin bad++; $display("FAIL sweep_write_count got=%0d exp=16", wr_cnt); end
        for (int c = 1; c <= 11; c++) if (lg_rd_en[c] === 1'b1) rd_got.push_back(lg_rd_ad[c]);
        total++; if (rd_got.size() != 4) begin bad++; $display("FAIL cell0_read_count got=%0d exp=4", rd_got.size()); end
        for (int i = 0; i < 4 && i < rd_got.size(); i++) begin
            total++; if (rd_got[i] !== exp_rd[i]) begin bad++; $display("FAIL cell0_read_addr i=%0d got=%0d exp=%0d", i, rd_got[i], exp_rd[i]); end
        end
        total++; if (lg_mask[11] !== 8'b0010_1111) begin bad++; $display("FAIL cell0_mask got=%b exp=00101111", lg_mask[11]); end
        total++; if (lg_ctr[11] !== 8'd3) begin bad++; $display("FAIL cell0_center got=%0d exp=3", lg_ctr[11]); end
        for (int j = 0; j < 8; j++) begin
            total++; if (lg_sur[11][j] !== exp_sur[j]) begin bad++; $display("FAIL cell0_surround j=%0d got=%0d exp=%0d", j, lg_sur[11][j], exp_sur[j]); end
        end
        total++; if (lg_mask[66] !== 8'h00) begin bad++; $display("FAIL cell5_mask got=%b exp=00000000", lg_mask[66]); end
        total++; if (lg_mask[176] !== 8'b1111_0100) begin bad++; $display("FAIL cell15_mask got=%b exp=11110100", lg_mask[176]); end
    endtask

    task automatic test_ant_update();
        int n, upd_cnt, wr_cnt;
        logic [AW+SB:0] e;
        exp_q.delete();
        for (int a = 0; a < GW*GH; a++) exp_q.push_back({1'b0, 4'(a), 8'd101});
        kick_start();
        log_sweep(n);
        total++; if (n != 177) begin bad++; $display("FAIL ant_busy_cycles got=%0d exp=177", n); end
        total++; if (cur_bank !== 1'b0) begin bad++; $display("FAIL ant_bank_after got=%b exp=0", cur_bank); end
        upd_cnt = 0;
        for (int c = 1; c <= n; c++) if (lg_upd[c] !== 2'd0) upd_cnt++;
        total++; if (upd_cnt != 1) begin bad++; $display("FAIL ant_update_count got=%0d exp=1", upd_cnt); end
        total++; if (lg_upd[121] !== 2'd1) begin bad++; $display("FAIL ant_update_cell10 got=%0d exp=1", lg_upd[121]); end
        wr_cnt = 0;
        for (int c = 1; c <= n; c++) begin
            if (lg_wr_en[c] === 1'b1) begin
                wr_cnt++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                total++;
                if ({lg_wr_bk[c], lg_wr_ad[c], lg_wr_dt[c]} !== e) begin
                    bad++;
                    $display("FAIL ant_write c=%0d got bk=%b ad=%0d d=%0d exp d=101", c, lg_wr_bk[c], lg_wr_ad[c], lg_wr_dt[c]);
                end
            end
        end
        total++; if (wr_cnt != 16) begin bad++; $display("FAIL ant_write_count got=%0d exp=16", wr_cnt); end
    endtask

    task automatic test_start_priority();
        int n, rdy_cnt, wr_cnt;
        logic [AW+SB:0] e;
        exp_q.delete();
        for (int a = 0; a < GW*GH; a++) exp_q.push_back({1'b1, 4'(a), 8'd102});
        @(negedge Clk);
        start = 1'b1; host_wr_valid = 1'b1; host_addr = 4'd3; host_data = 8'hEE;
        #1;
        total++; if (host_wr_ready !== 1'b0) begin bad++; $display("FAIL prio_ready got=%b exp=0", host_wr_ready); end
        total++; if (mem_wr_en !== 1'b0) begin bad++; $display("FAIL prio_wr_en got=%b exp=0", mem_wr_en); end
        @(posedge Clk);
        #1 start = 1'b0;
        log_sweep(n);
        host_wr_valid = 1'b0;
        total++; if (n != 177) begin bad++; $display("FAIL prio_busy_cycles got=%0d exp=177", n); end
        rdy_cnt = 0;
        for (int c = 1; c <= n; c++) if (lg_rdy[c] !== 1'b0) rdy_cnt++;
        total++; if (rdy_cnt != 0) begin bad++; $display("FAIL busy_ready_cycles got=%0d exp=0", rdy_cnt); end
        wr_cnt = 0;
        for (int c = 1; c <= n; c++) begin
            if (lg_wr_en[c] === 1'b1) begin
                wr_cnt++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                total++;
                if ({lg_wr_bk[c], lg_wr_ad[c], lg_wr_dt[c]} !== e) begin
                    bad++;
                    $display("FAIL busy_write c=%0d got bk=%b ad=%0d d=%0d exp bk=1 ad=%0d d=102", c, lg_wr_bk[c], lg_wr_ad[c], lg_wr_dt[c], e[11:8]);
                end
            end
        end
        total++; if (wr_cnt != 16) begin bad++; $display("FAIL busy_write_count got=%0d exp=16", wr_cnt); end
        total++; if (cur_bank !== 1'b1) begin bad++; $display("FAIL prio_bank_after got=%b exp=1", cur_bank); end
    endtask

    task automatic test_reset_mid_sweep();
        int wr_cnt, done_cnt, busy_cnt;
        kick_start();
        repeat (59) @(negedge Clk);
        @(negedge Clk);
        total++; if ({busy, cur_bank} !== 2'b11) begin bad++; $display("FAIL mid_pre_state got busy=%b bank=%b exp 1 1", busy, cur_bank); end
        total++; if ({cell_x, cell_y} !== {2'd1, 2'd1}) begin bad++; $display("FAIL mid_pre_cell got x=%0d y=%0d exp 1 1", cell_x, cell_y); end
        Reset_n = 1'b0;
        #1;
        total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL mid_state got=%0d exp=0", dbg_state); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
        total++; if (cur_bank !== 1'b0) begin bad++; $display("FAIL mid_bank got=%b exp=0", cur_bank); end
        total++; if ({cell_x, cell_y} !== 4'h0) begin bad++; $display("FAIL mid_cell got=%h exp=0", {cell_x, cell_y}); end
        total++; if (dp_border_mask !== 8'h00) begin bad++; $display("FAIL mid_mask got=%b exp=0", dp_border_mask); end
        total++; if ({mem_rd_en, mem_wr_en} !== 2'b00) begin bad++; $display("FAIL mid_mem_en got=%b exp=00", {mem_rd_en, mem_wr_en}); end
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        wr_cnt = 0; done_cnt = 0; busy_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge Clk);
            if (mem_wr_en !== 1'b0) wr_cnt++;
            if (done !== 1'b0) done_cnt++;
            if (busy !== 1'b0) busy_cnt++;
        end
        total++; if (wr_cnt != 0) begin bad++; $display("FAIL mid_after_writes got=%0d exp=0", wr_cnt); end
        total++; if (done_cnt != 0) begin bad++; $display("FAIL mid_after_done got=%0d exp=0", done_cnt); end
        total++; if (busy_cnt != 0) begin bad++; $display("FAIL mid_after_busy got=%0d exp=0", busy_cnt); end
        total++; if (host_wr_ready !== 1'b1) begin bad++; $display("FAIL mid_after_ready got=%b exp=1", host_wr_ready); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_host_write(1'b0, 1'b0);
        test_sweep_pattern();
        test_host_write(1'b1, 1'b1);
        test_ant_update();
        test_start_priority();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
